// File: rtl/cr_kme_fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// cr_kme_fifo_arb_pkg
//   Shared types and helpers for the cr_kme FIFO write-port arbiter.
//   - arb_state_e : arbiter FSM state (IDLE / LOCKED)
//   - calc_req_w  : index width for a requester count (min 1 bit)
//   - rr_next     : round-robin successor with explicit wrap, so that
//                   non-power-of-two requester counts wrap correctly
// ---------------------------------------------------------------------------
package cr_kme_fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of the stall/idle counter that feeds the lock timeout.
  localparam int IDLE_CNT_W = 16;

  function automatic int calc_req_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Successor of ptr in 0..n-1. Compare-and-reset instead of truncation,
  // because n need not be a power of two.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/cr_kme_rr_pick.sv
// ---------------------------------------------------------------------------
// cr_kme_rr_pick
//   Purely combinational rotate-priority picker. Finds the first asserted
//   request starting at rr_ptr and searching upward, wrapping at NUM_REQ.
//
//   Ports
//     req    : in  [NUM_REQ-1:0] request vector
//     rr_ptr : in  [REQ_W-1:0]   highest-priority index this cycle
//     found  : out               at least one request asserted
//     idx    : out [REQ_W-1:0]   winning index (rr_ptr when none found)
// ---------------------------------------------------------------------------
module cr_kme_rr_pick
  import cr_kme_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int REQ_W   = calc_req_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   rr_ptr,
  output logic               found,
  output logic [REQ_W-1:0]   idx
);

  // Scan from the lowest priority offset to the highest so that the
  // nearest request after rr_ptr overwrites every farther one.
  always_comb begin
    int               cand;
    logic [REQ_W-1:0] cidx;
    cand  = 0;
    cidx  = '0;
    found = 1'b0;
    idx   = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = REQ_W'(cand);
      if (req[cidx]) begin
        found = 1'b1;
        idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/cr_kme_fifo_arb.sv
// ---------------------------------------------------------------------------
// cr_kme_fifo_arb
//   Packet-locking round-robin arbiter sharing the single cr_kme_fifo write
//   port among NUM_REQ requesters. Once a multi-beat packet starts, the
//   grant stays with its owner until the last beat so packets never
//   interleave in the FIFO. The FIFO stall is honoured combinationally, so
//   no write is ever issued into a full FIFO. An owner that leaves its
//   packet idle for LOCK_TIMEOUT consecutive cycles raises a sticky error;
//   the lock itself is kept, recovery is by reset.
//
//   Ports
//     clk, rst_n       : clock, asynchronous active-low reset
//     req_valid        : in  [NUM_REQ-1:0]           beat valid per requester
//     req_data         : in  [NUM_REQ*DATA_SIZE-1:0] requester i at [i*DATA_SIZE +: DATA_SIZE]
//     req_last         : in  [NUM_REQ-1:0]           final beat of packet
//     req_ack          : out [NUM_REQ-1:0]           beat accepted (one-hot or zero)
//     fifo_in          : out [DATA_SIZE-1:0]         beat to FIFO (zero when no winner)
//     fifo_in_valid    : out                         FIFO write enable
//     fifo_in_stall    : in                          FIFO has no free slot
//     grant_id         : out [REQ_W-1:0]             owner, or IDLE candidate / rr_ptr
//     locked           : out                         arbiter holds a packet lock
//     err_lock_timeout : out                         sticky owner-idle timeout
// ---------------------------------------------------------------------------
module cr_kme_fifo_arb
  import cr_kme_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_SIZE    = 34,
  parameter  int LOCK_TIMEOUT = 255,
  localparam int REQ_W        = calc_req_w(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [DATA_SIZE-1:0]         fifo_in,
  output logic                         fifo_in_valid,
  input  logic                         fifo_in_stall,
  output logic [REQ_W-1:0]             grant_id,
  output logic                         locked,
  output logic                         err_lock_timeout
);

  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_VAL  = IDLE_CNT_W'(LOCK_TIMEOUT);
  localparam logic [IDLE_CNT_W-1:0] IDLE_CNT_MAX = '1;

  arb_state_e              state;
  logic [REQ_W-1:0]        rr_ptr;
  logic [REQ_W-1:0]        owner;
  logic [IDLE_CNT_W-1:0]   idle_cnt;
  logic [IDLE_CNT_W-1:0]   idle_cnt_nxt;

  logic                    pick_found;
  logic [REQ_W-1:0]        pick_idx;
  logic                    win_found;
  logic [REQ_W-1:0]        win_idx;
  logic                    win_last;
  logic [REQ_W-1:0]        rr_after_win;
  logic [DATA_SIZE-1:0]    beat [NUM_REQ];

  cr_kme_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      beat[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Winner: the owner while locked (nobody else is considered), otherwise
  // the rotate-priority pick. The pick index falls back to rr_ptr when no
  // request is present, which is also what grant_id reports.
  always_comb begin
    if (state == LOCKED) begin
      win_found = 1'b1;
      win_idx   = owner;
    end else begin
      win_found = pick_found;
      win_idx   = pick_idx;
    end
  end

  always_comb begin
    fifo_in_valid = win_found & req_valid[win_idx] & ~fifo_in_stall;
    req_ack       = '0;
    if (fifo_in_valid) req_ack[win_idx] = 1'b1;
    fifo_in       = win_found ? beat[win_idx] : '0;
    win_last      = req_last[win_idx];
    rr_after_win  = REQ_W'(rr_next(int'(win_idx), NUM_REQ));
    grant_id      = win_idx;
  end

  // Owner-idle counter: only cycles where the owner has nothing to offer
  // count. A stalled-but-valid owner is waiting on the FIFO, not idle.
  always_comb begin
    idle_cnt_nxt = '0;
    if (state == LOCKED && !req_valid[owner]) begin
      idle_cnt_nxt = (idle_cnt == IDLE_CNT_MAX) ? idle_cnt : idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      owner            <= '0;
      idle_cnt         <= '0;
      err_lock_timeout <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
      // Sticky; the lock is deliberately not broken on timeout.
      if (idle_cnt_nxt >= TIMEOUT_VAL) err_lock_timeout <= 1'b1;
      case (state)
        IDLE: begin
          if (fifo_in_valid) begin
            if (win_last) begin
              rr_ptr <= rr_after_win;
            end else begin
              state <= LOCKED;
              owner <= win_idx;
            end
          end
        end
        LOCKED: begin
          if (fifo_in_valid && win_last) begin
            state  <= IDLE;
            rr_ptr <= rr_after_win;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
module tb_cr_kme_fifo_arb;
  localparam int NREQ  = 4;
  localparam int DW    = 34;
  localparam int TO    = 4;
  localparam int DW3   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A: 4 requesters, LOCK_TIMEOUT=4 ----------------
  logic [NREQ-1:0]    rv, rl, req_ack;
  logic [DW-1:0]      rd [NREQ];
  logic [NREQ*DW-1:0] req_data;
  logic [DW-1:0]      fifo_in;
  logic               fifo_in_valid, stall;
  logic [1:0]         grant_id;
  logic               locked, err;

  always_comb for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = rd[i];

  cr_kme_fifo_arb #(.NUM_REQ(NREQ), .DATA_SIZE(DW), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_data(req_data), .req_last(rl),
    .req_ack(req_ack), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(stall), .grant_id(grant_id), .locked(locked), .err_lock_timeout(err)
  );

  // ---------------- DUT B: 3 requesters (non-power-of-two wrap) ----------
  logic [2:0]       rv3, rl3, ack3;
  logic [3*DW3-1:0] rd3;
  logic [DW3-1:0]   fi3;
  logic             fv3, stall3, lk3, er3;
  logic [1:0]       gid3;

  cr_kme_fifo_arb #(.NUM_REQ(3), .DATA_SIZE(DW3), .LOCK_TIMEOUT(TO)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_data(rd3), .req_last(rl3),
    .req_ack(ack3), .fifo_in(fi3), .fifo_in_valid(fv3),
    .fifo_in_stall(stall3), .grant_id(gid3), .locked(lk3), .err_lock_timeout(er3)
  );

  int checks = 0;
  int passed = 0;

  // ---------------- reference model (for DUT A) ----------------
  logic          m_locked, m_err;
  int            m_owner, m_rr, m_idle;
  int            e_win;
  logic          e_xfer;
  logic [3:0]    e_ack;
  logic [DW-1:0] e_data;

  // depth-2 FIFO attached to DUT A, plus scoreboard of expected write order
  logic          fifo_mode;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] sbq[$];
  int            ovf_cnt, ord_err;

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_err = 1'b0; m_owner = 0; m_rr = 0; m_idle = 0;
  endtask

  task automatic model_eval();
    logic found;
    int   w, c;
    found = 1'b0; w = m_rr; c = 0;
    if (m_locked) begin
      found = 1'b1; w = m_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_rr + k) % NREQ;
        if (!found && rv[c]) begin found = 1'b1; w = c; end
      end
    end
    e_win  = w;
    e_xfer = found && rv[w] && !stall;
    e_ack  = e_xfer ? 4'(1 << w) : 4'b0;
    e_data = found ? rd[w] : '0;
  endtask

  task automatic model_commit();
    if (m_locked) begin
      if (rv[m_owner]) m_idle = 0;
      else if (m_idle < 65535) m_idle++;
      if (m_idle >= TO) m_err = 1'b1;
      if (e_xfer && rl[e_win]) begin m_locked = 1'b0; m_rr = (e_win + 1) % NREQ; end
    end else begin
      m_idle = 0;
      if (e_xfer) begin
        if (rl[e_win]) m_rr = (e_win + 1) % NREQ;
        else begin m_locked = 1'b1; m_owner = e_win; end
      end
    end
  endtask

  function automatic logic [44:0] obs_v();
    return {req_ack, fifo_in_valid, fifo_in, grant_id, locked, err, dut.rr_ptr};
  endfunction

  function automatic logic [44:0] exp_v();
    return {e_ack, e_xfer, e_data, 2'(e_win), m_locked, m_err, 2'(m_rr)};
  endfunction

  task automatic cyc_eval();
    @(negedge clk);
    model_eval();
  endtask

  task automatic cyc_commit();
    logic          wr;
    logic [DW-1:0] wd, a, b;
    wr = fifo_in_valid; wd = fifo_in;
    if (fifo_mode) begin
      if (wr && fq.size() >= 2) ovf_cnt++;
      if (fq.size() > 0 && $urandom_range(0, 1) == 1) begin
        a = fq.pop_front();
        b = (sbq.size() > 0) ? sbq.pop_front() : '0;
        if (a !== b) ord_err++;
      end
      if (wr && fq.size() < 2) fq.push_back(wd);
      if (e_xfer) sbq.push_back(e_data);
    end
    model_commit();
    @(posedge clk);
    #1;
    if (fifo_mode) stall = (fq.size() == 2);
  endtask

  task automatic clear_inputs();
    rv = '0; rl = '0; stall = 1'b0; fifo_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) rd[i] = '0;
    rv3 = '0; rl3 = '0; rd3 = '0; stall3 = 1'b0;
    fq.delete(); sbq.delete(); ovf_cnt = 0; ord_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    cyc_eval();
    checks++; if (obs_v() === exp_v()) passed++;
    else $display("FAIL reset_idle: got %h want %h", obs_v(), exp_v());
    rv = 4'b1010;
    #1 model_eval();
    checks++; if (obs_v() === exp_v()) passed++;
    else $display("FAIL reset_pick: got %h want %h", obs_v(), exp_v());
    rv = '0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    do_reset();
    rv = 4'b0101; rl = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      rd[0] = rnd(); rd[2] = rnd();
      cyc_eval();
      checks++; if (obs_v() === exp_v()) passed++;
      else $display("FAIL alt_model cyc%0d: got %h want %h", i, obs_v(), exp_v());
      checks++; if (req_ack === ((i % 2 == 0) ? 4'b0001 : 4'b0100)) passed++;
      else $display("FAIL alt_seq cyc%0d: ack %b", i, req_ack);
      cyc_commit();
    end
  endtask

  task automatic test_lock();
    int nlock;
    do_reset();
    rv = 4'b0001; rl = 4'b0001; rd[0] = rnd();
    cyc_eval();
    checks++; if (obs_v() === exp_v()) passed++;
    else $display("FAIL lock_pre: got %h want %h", obs_v(), exp_v());
    cyc_commit();
    rv = 4'b0011; rl = 4'b0001; nlock = 0;
    for (int i = 0; i < 4; i++) begin
      rl[1] = (i == 2); rd[0] = rnd(); rd[1] = rnd();
      cyc_eval();
      checks++; if (obs_v() === exp_v()) passed++;
      else $display("FAIL lock_model cyc%0d: got %h want %h", i, obs_v(), exp_v());
      checks++; if (req_ack === ((i < 3) ? 4'b0010 : 4'b0001)) passed++;
      else $display("FAIL lock_seq cyc%0d: ack %b", i, req_ack);
      if (locked) nlock++;
      cyc_commit();
    end
    checks++; if (nlock == 2) passed++;
    else $display("FAIL lock_cycles: got %0d want 2", nlock);
  endtask

  task automatic test_stall();
    do_reset();
    rv = 4'b0100; rl = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      rd[2] = rnd();
      stall = (i >= 1 && i <= 5);
      rl[2] = (i == 7);
      cyc_eval();
      checks++; if (obs_v() === exp_v()) passed++;
      else $display("FAIL stall_model cyc%0d: got %h want %h", i, obs_v(), exp_v());
      if (stall) begin
        checks++; if ({fifo_in_valid, req_ack, locked, grant_id} === {1'b0, 4'b0000, 1'b1, 2'd2}) passed++;
        else $display("FAIL stall_hold cyc%0d: valid %b ack %b locked %b gid %0d",
                      i, fifo_in_valid, req_ack, locked, grant_id);
      end
      cyc_commit();
    end
    stall = 1'b0;
  endtask

  task automatic test_fifo_random();
    int rem [NREQ];
    do_reset();
    fifo_mode = 1'b1;
    for (int r = 0; r < NREQ; r++) begin rem[r] = 0; rd[r] = rnd(); end
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (rem[r] == 0) rem[r] = $urandom_range(1, 4);
        rv[r] = ($urandom_range(0, 3) != 0);
        rl[r] = (rem[r] == 1);
      end
      cyc_eval();
      checks++; if (obs_v() === exp_v()) passed++;
      else $display("FAIL rand_model cyc%0d: got %h want %h", i, obs_v(), exp_v());
      if (e_xfer) begin rem[e_win]--; rd[e_win] = rnd(); end
      cyc_commit();
    end
    checks++; if (ovf_cnt == 0) passed++;
    else $display("FAIL fifo_overflow: got %0d writes into full FIFO want 0", ovf_cnt);
    checks++; if (ord_err == 0) passed++;
    else $display("FAIL fifo_order: got %0d out-of-order beats want 0", ord_err);
    fifo_mode = 1'b0; stall = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    rv = 4'b1000; rl = 4'b0000; rd[3] = rnd();
    cyc_eval();
    checks++; if (obs_v() === exp_v()) passed++;
    else $display("FAIL to_start: got %h want %h", obs_v(), exp_v());
    cyc_commit();
    rv = '0;
    for (int i = 0; i < 4; i++) begin
      cyc_eval();
      checks++; if (obs_v() === exp_v()) passed++;
      else $display("FAIL to_model cyc%0d: got %h want %h", i, obs_v(), exp_v());
      checks++; if (err === 1'b0) passed++;
      else $display("FAIL to_early cyc%0d: err %b want 0", i, err);
      cyc_commit();
    end
    cyc_eval();
    checks++; if ({err, locked} === 2'b11) passed++;
    else $display("FAIL to_rise: err %b locked %b want 1 1", err, locked);
    cyc_commit();
    rv = 4'b1000; rl = 4'b1000; rd[3] = rnd();
    cyc_eval();
    checks++; if (obs_v() === exp_v()) passed++;
    else $display("FAIL to_finish: got %h want %h", obs_v(), exp_v());
    cyc_commit();
    rv = '0; rl = '0;
    cyc_eval();
    checks++; if ({err, locked} === 2'b10) passed++;
    else $display("FAIL to_sticky: err %b locked %b want 1 0", err, locked);
    cyc_commit();
    do_reset();
    cyc_eval();
    checks++; if (err === 1'b0) passed++;
    else $display("FAIL to_clear: err %b want 0", err);
    cyc_commit();
  endtask

  task automatic test_wrap3();
    do_reset();
    rv3 = 3'b111; rl3 = 3'b111;
    for (int i = 0; i < 7; i++) begin
      rd3 = {DW3'($urandom), DW3'($urandom), DW3'($urandom)};
      @(negedge clk);
      checks++;
      if ({gid3, ack3, fv3, fi3} === {2'(i % 3), 3'(1 << (i % 3)), 1'b1, rd3[(i % 3)*DW3 +: DW3]}) passed++;
      else $display("FAIL wrap3 cyc%0d: gid %0d ack %b data %h want gid %0d", i, gid3, ack3, fi3, i % 3);
      @(posedge clk); #1;
    end
    rv3 = '0; rl3 = '0;
  endtask

  task automatic test_reset_locked();
    do_reset();
    rv = 4'b0010; rl = 4'b0000; rd[1] = rnd(); rd[0] = rnd();
    cyc_eval();
    checks++; if (obs_v() === exp_v()) passed++;
    else $display("FAIL rl_start: got %h want %h", obs_v(), exp_v());
    cyc_commit();
    rv = 4'b0011;
    cyc_eval();
    checks++; if ({locked, grant_id} === {1'b1, 2'd1}) passed++;
    else $display("FAIL rl_locked: locked %b gid %0d want 1 1", locked, grant_id);
    rst_n = 1'b0;
    #1;
    checks++; if ({locked, grant_id} === {1'b0, 2'd0}) passed++;
    else $display("FAIL rl_async: locked %b gid %0d want 0 0", locked, grant_id);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    cyc_eval();
    checks++; if (obs_v() === exp_v()) passed++;
    else $display("FAIL rl_after: got %h want %h", obs_v(), exp_v());
    checks++; if (req_ack === 4'b0001) passed++;
    else $display("FAIL rl_winner: ack %b want 0001", req_ack);
    cyc_commit();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alternate();
    test_lock();
    test_stall();
    test_timeout();
    test_wrap3();
    test_reset_locked();
    test_fifo_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
